return_address_stack: RTL and testbench

Parametrised return-address stack (RAS) for the program-counter unit: on a call it stores the return address, on a return it supplies the predicted target, and it survives overflow by wrapping. Unlike the single fixed call stack it supersedes, it adds configurable depth and width, count and valid reporting, overflow and underflow flags, and one checkpoint/restore slot for branch-mispredict recovery. It sits beside the PC decoder and calculator; `stack_top` feeds the next-PC mux.

---
 rtl/pc_pkg.sv | 27 ++
 rtl/ras_storage.sv | 32 +++
 rtl/return_address_stack.sv | 155 +++++++++++++++
 tb/tb_return_address_stack.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter unit.
// Holds return-address-stack constants, checkpoint slot and op decode.
package pc_pkg;

    localparam int RAS_DEPTH         = 8;
    localparam int RAS_RETURN_OFFSET = 1;

    // Checkpoint fields are sized for the largest supported stack so one
    // type serves every parametrisation; the top narrows them on use.
    localparam int RAS_MAX_WIDTH = 64;
    localparam int RAS_MAX_PTR   = 16;

    typedef struct packed {
        logic [RAS_MAX_PTR-1:0]   tos;
        logic [RAS_MAX_PTR:0]     count;
        logic [RAS_MAX_WIDTH-1:0] top;
    } ras_ckpt_t;

    typedef enum logic [2:0] {
        RAS_IDLE,
        RAS_RESTORE,
        RAS_SWAP,
        RAS_PUSH,
        RAS_POP
    } ras_op_e;

endpackage

// File: rtl/ras_storage.sv
// Return-address-stack entry array.
// One write port, one asynchronous read port, async active-low clear.
module ras_storage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Entry array: cleared on reset, single write per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/return_address_stack.sv
// Return-address stack with wrap-on-overflow, flags and one
// checkpoint slot for mispredict recovery.
module return_address_stack
    import pc_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = RAS_DEPTH,
    parameter int RETURN_OFFSET = RAS_RETURN_OFFSET,
    parameter int PW            = $clog2(DEPTH),
    parameter int CW            = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             do_push,
    input  logic             do_pop,
    input  logic [WIDTH-1:0] push_addr,
    input  logic             checkpoint,
    input  logic             restore,
    output logic [WIDTH-1:0] stack_top,
    output logic             top_valid,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    logic [PW-1:0]    tos_q, tos_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    ras_ckpt_t        ckpt_q, ckpt_d;

    ras_op_e          op;
    logic             mem_we;
    logic [PW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] top_entry;
    logic [WIDTH-1:0] push_val;

    logic [PW-1:0]    ck_tos;
    logic [CW-1:0]    ck_count;
    logic [WIDTH-1:0] ck_top;
    logic             ckpt_unused;

    assign push_val = push_addr + WIDTH'(RETURN_OFFSET);

    assign ck_tos      = ckpt_q.tos[PW-1:0];
    assign ck_count    = ckpt_q.count[CW-1:0];
    assign ck_top      = ckpt_q.top[WIDTH-1:0];
    assign ckpt_unused = ^ckpt_q;

    ras_storage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_storage (
        .clk   (clk),
        .rst_n (reset),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (tos_q),
        .rdata (top_entry)
    );

    // Restore wins over everything; a push with a pop is a swap in place.
    always_comb begin
        op = RAS_IDLE;
        if (restore) begin
            op = RAS_RESTORE;
        end else if (do_push && do_pop) begin
            op = RAS_SWAP;
        end else if (do_push) begin
            op = RAS_PUSH;
        end else if (do_pop) begin
            op = RAS_POP;
        end
    end

    // Next pointer, count, flags, storage write and checkpoint capture.
    always_comb begin
        tos_d       = tos_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        ckpt_d      = ckpt_q;
        mem_we      = 1'b0;
        mem_waddr   = tos_q;
        mem_wdata   = push_val;

        if (checkpoint && !restore) begin
            ckpt_d.tos   = RAS_MAX_PTR'(tos_q);
            ckpt_d.count = (RAS_MAX_PTR + 1)'(count_q);
            ckpt_d.top   = RAS_MAX_WIDTH'(top_entry);
        end

        unique case (op)
            RAS_RESTORE: begin
                tos_d     = ck_tos;
                count_d   = ck_count;
                mem_we    = 1'b1;
                mem_waddr = ck_tos;
                mem_wdata = ck_top;
            end
            RAS_SWAP: begin
                mem_we = 1'b1;
                if (count_q == '0) begin
                    count_d = CW'(1);
                end
            end
            RAS_PUSH: begin
                mem_we    = 1'b1;
                mem_waddr = tos_q + PW'(1);
                tos_d     = tos_q + PW'(1);
                if (count_q == CW'(DEPTH)) begin
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            RAS_POP: begin
                if (count_q == '0) begin
                    underflow_d = 1'b1;
                end else begin
                    tos_d   = tos_q - PW'(1);
                    count_d = count_q - CW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Stack state and flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tos_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            ckpt_q      <= '0;
        end else begin
            tos_q       <= tos_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            ckpt_q      <= ckpt_d;
        end
    end

    assign top_valid = (count_q != '0);
    assign stack_top = top_valid ? top_entry : '0;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_return_address_stack.sv
// Self-checking bench for return_address_stack (DEPTH=4).
// Directed scenarios followed by random traffic against a stack model.
module tb_return_address_stack;

    localparam int W = 32;
    localparam int D = 4;
    localparam int CW = $clog2(D + 1);

    logic          clk;
    logic          reset;
    logic          do_push;
    logic          do_pop;
    logic [W-1:0]  push_addr;
    logic          checkpoint;
    logic          restore;
    logic [W-1:0]  stack_top;
    logic          top_valid;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] m_mem [D];
    int           m_tos;
    int           m_cnt;
    int           ck_tos;
    int           ck_cnt;
    logic [W-1:0] ck_top;
    logic         m_ov;
    logic         m_un;

    return_address_stack #(
        .WIDTH         (W),
        .DEPTH         (D),
        .RETURN_OFFSET (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .do_push    (do_push),
        .do_pop     (do_pop),
        .push_addr  (push_addr),
        .checkpoint (checkpoint),
        .restore    (restore),
        .stack_top  (stack_top),
        .top_valid  (top_valid),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_mem[i] = '0;
        m_tos  = 0;
        m_cnt  = 0;
        ck_tos = 0;
        ck_cnt = 0;
        ck_top = '0;
        m_ov   = 1'b0;
        m_un   = 1'b0;
    endtask

    task automatic model_edge(input logic p, input logic q,
                              input logic [W-1:0] a, input logic c,
                              input logic r);
        logic [W-1:0] v;
        v    = a + 32'd1;
        m_ov = 1'b0;
        m_un = 1'b0;
        if (r) begin
            m_tos        = ck_tos;
            m_cnt        = ck_cnt;
            m_mem[m_tos] = ck_top;
        end else begin
            if (c) begin
                ck_tos = m_tos;
                ck_cnt = m_cnt;
                ck_top = m_mem[m_tos];
            end
            if (p && q) begin
                m_mem[m_tos] = v;
                if (m_cnt == 0) m_cnt = 1;
            end else if (p) begin
                m_tos        = (m_tos + 1) % D;
                m_mem[m_tos] = v;
                if (m_cnt == D) m_ov = 1'b1;
                else m_cnt++;
            end else if (q) begin
                if (m_cnt > 0) begin
                    m_tos = (m_tos + D - 1) % D;
                    m_cnt--;
                end else begin
                    m_un = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_top"}, stack_top, (m_cnt != 0) ? m_mem[m_tos] : '0);
        chk({tag, "_valid"}, 32'(top_valid), 32'(m_cnt != 0));
        chk({tag, "_count"}, 32'(count), 32'(m_cnt));
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ov));
        chk({tag, "_unf"}, 32'(underflow), 32'(m_un));
    endtask

    task automatic step(input logic p, input logic q, input logic [W-1:0] a,
                        input logic c, input logic r, input string tag);
        do_push    = p;
        do_pop     = q;
        push_addr  = a;
        checkpoint = c;
        restore    = r;
        @(posedge clk);
        model_edge(p, q, a, c, r);
        #1;
        check_all(tag);
        do_push    = 1'b0;
        do_pop     = 1'b0;
        checkpoint = 1'b0;
        restore    = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        push_addr  = '0;
        checkpoint = 1'b0;
        restore    = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Three calls then three returns.
        step(1, 0, 32'h100, 0, 0, "push1");
        step(1, 0, 32'h200, 0, 0, "push2");
        step(1, 0, 32'h300, 0, 0, "push3");
        chk("top3", stack_top, 32'h301);
        step(0, 1, '0, 0, 0, "pop1");
        chk("pop1_lit", stack_top, 32'h201);
        step(0, 1, '0, 0, 0, "pop2");
        chk("pop2_lit", stack_top, 32'h101);
        step(0, 1, '0, 0, 0, "pop3");
        chk("pop3_valid", 32'(top_valid), 32'd0);

        // Overflow: fifth push discards the oldest entry.
        for (int i = 1; i <= 5; i++)
            step(1, 0, 32'(i * 16), 0, 0, "ovf_push");
        chk("ovf_lit", 32'(overflow), 32'd1);
        chk("ovf_cnt", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_pop_lit", stack_top, 32'(81 - i * 16));
            step(0, 1, '0, 0, 0, "ovf_pop");
        end

        // Underflow on empty stack, then flag clears.
        step(0, 1, '0, 0, 0, "unf");
        chk("unf_lit", 32'(underflow), 32'd1);
        step(0, 0, '0, 0, 0, "unf_clear");

        // Push and pop together replace the top.
        step(1, 0, 32'h100, 0, 0, "sw_push1");
        step(1, 0, 32'h200, 0, 0, "sw_push2");
        step(1, 1, 32'h700, 0, 0, "swap");
        chk("swap_lit", stack_top, 32'h701);

        // Checkpoint, disturb, restore.
        step(0, 1, '0, 0, 0, "ck_prep_pop");
        step(1, 0, 32'h200, 0, 0, "ck_prep_push");
        step(0, 0, '0, 1, 0, "ck_take");
        step(0, 1, '0, 0, 0, "ck_pop1");
        step(0, 1, '0, 0, 0, "ck_pop2");
        step(1, 0, 32'h900, 0, 0, "ck_push");
        step(1, 1, 32'h123, 1, 1, "ck_restore");
        chk("restore_lit", stack_top, 32'h201);
        chk("restore_cnt", 32'(count), 32'd2);
        step(0, 1, '0, 0, 0, "ck_after_pop");

        // Address wrap at the top of the address space.
        step(1, 0, 32'hFFFF_FFFF, 0, 0, "wrap_push");
        chk("wrap_lit", stack_top, 32'h0);

        // Asynchronous reset between edges during a push run.
        step(1, 0, 32'h10, 0, 0, "ar_push");
        do_push   = 1'b1;
        push_addr = 32'h20;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        do_push = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step(0, 0, '0, 0, 1, "restore_empty");
        step(1, 0, 32'h40, 0, 0, "post_rst");
        chk("post_rst_lit", stack_top, 32'h41);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            logic         p, q, c, r;
            logic [W-1:0] a;
            p = 1'($urandom_range(0, 1));
            q = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 11) == 0);
            a = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
            step(p, q, a, c, r, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
